// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester, memory and grant signals shared by the arbiter and its clients
interface mem_port_arbiter_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
);
    logic                  a_req, a_we, a_gnt, a_rvalid;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [DATA_WIDTH-1:0] a_wdata;
    logic                  b_req, b_we, b_gnt, b_rvalid;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [DATA_WIDTH-1:0] b_wdata;
    logic                  sel, mem_en, mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata, mem_rdata, rdata;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, mem_rdata,
        output a_gnt, a_rvalid, b_gnt, b_rvalid, sel, mem_en, mem_we, mem_addr, mem_wdata, rdata
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, mem_rdata,
        input  a_gnt, a_rvalid, b_gnt, b_rvalid, sel, mem_en, mem_we, mem_addr, mem_wdata, rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one single-ported memory between fetch (A) and load/store (B)
module mem_port_arbiter #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 16,
    parameter int READ_LATENCY = 1,
    parameter int MAX_HOLD     = 8
) (
    input logic               clk,
    input logic               reset_n,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_t;
    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

    state_t                  state;
    logic                    last_a;
    logic [7:0]              hold_cnt, hold_nxt;
    logic [READ_LATENCY-1:0] pipe_v, pipe_a;
    logic [ADDR_WIDTH-1:0]   addr_mux;
    logic [DATA_WIDTH-1:0]   wdata_mux;
    logic                    en, we, hold_hit, go_a, go_b, go_idle;

    always_comb begin
        addr_mux  = bus.sel ? bus.a_addr : bus.b_addr;
        wdata_mux = bus.sel ? bus.a_wdata : bus.b_wdata;
        en        = (bus.a_gnt & bus.a_req) | (bus.b_gnt & bus.b_req);
        we        = en & (bus.sel ? bus.a_we : bus.b_we);
        hold_nxt  = (en && hold_cnt < HOLD_MAX) ? hold_cnt + 8'd1 : hold_cnt;
        hold_hit  = hold_nxt == HOLD_MAX;
        // last_a=0 means B went last, so A wins a tie out of IDLE
        go_a      = bus.a_req & (((state == IDLE) & (~bus.b_req | ~last_a)) |
                                 ((state == GNT_B) & (~bus.b_req | hold_hit)));
        go_b      = bus.b_req & (((state == IDLE) & (~bus.a_req | last_a)) |
                                 ((state == GNT_A) & (~bus.a_req | hold_hit)));
        go_idle   = (state != IDLE) & ~bus.a_req & ~bus.b_req;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            bus.a_gnt <= 1'b0;
            bus.b_gnt <= 1'b0;
            bus.sel   <= 1'b0;
            last_a    <= 1'b0;
            hold_cnt  <= 8'd0;
        end else if (go_a | go_b) begin
            state     <= go_a ? GNT_A : GNT_B;
            bus.a_gnt <= go_a;
            bus.b_gnt <= go_b;
            bus.sel   <= go_a;
            last_a    <= go_a;
            hold_cnt  <= 8'd0;
        end else if (go_idle) begin
            state     <= IDLE;
            bus.a_gnt <= 1'b0;
            bus.b_gnt <= 1'b0;
            hold_cnt  <= hold_nxt;
        end else begin
            hold_cnt  <= hold_nxt;
        end
    end

    // One tag per accepted read; the oldest stage lines up with mem_rdata
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pipe_v <= '0;
            pipe_a <= '0;
        end else begin
            pipe_v <= READ_LATENCY'({pipe_v, en & ~we});
            pipe_a <= READ_LATENCY'({pipe_a, bus.sel});
        end
    end

    assign bus.mem_en    = en;
    assign bus.mem_we    = we;
    assign bus.mem_addr  = addr_mux;
    assign bus.mem_wdata = wdata_mux;
    assign bus.rdata     = bus.mem_rdata;
    assign bus.a_rvalid  = reset_n & pipe_v[READ_LATENCY-1] & pipe_a[READ_LATENCY-1];
    assign bus.b_rvalid  = reset_n & pipe_v[READ_LATENCY-1] & ~pipe_a[READ_LATENCY-1];
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized scoreboard bench with a behavioural arbitration and memory model
module tb_mem_port_arbiter;
    localparam int L    = 3;
    localparam int MAXH = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) bus ();
    mem_port_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .READ_LATENCY(L), .MAX_HOLD(MAXH)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    typedef struct { int own; logic [15:0] data; int due; } exp_t;
    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] init_val(input logic [7:0] a);
        return (16'(a) * 16'h9e37) ^ 16'h5a5a;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
        end
    endtask

    // Memory environment: READ_LATENCY-cycle read pipe, writes land at the accepting edge
    logic [15:0] tmem [256];
    bit          twr  [256];
    logic [15:0] dl   [L];
    assign bus.mem_rdata = dl[L-1];
    always @(posedge clk) begin
        for (int i = L - 1; i > 0; i--) dl[i] <= dl[i-1];
        dl[0] <= 16'hdead;
        if (bus.mem_en && bus.mem_we) begin
            tmem[bus.mem_addr[7:0]] <= bus.mem_wdata;
            twr[bus.mem_addr[7:0]]  <= 1'b1;
        end else if (bus.mem_en) begin
            dl[0] <= twr[bus.mem_addr[7:0]] ? tmem[bus.mem_addr[7:0]] : init_val(bus.mem_addr[7:0]);
        end
    end

    // Reference model: owner 0=none 1=A 2=B, evaluated once per cycle from the live requests
    int          m_own = 0, m_last = 2, m_cnt = 0, nx, n;
    bit          m_sel = 1'b0, e_en, e_we, rx, ry;
    logic [15:0] e_addr, e_wd;
    logic [15:0] rmem [256];
    bit          rwr  [256];

    always @(negedge clk) begin
        e_en   = (m_own == 1 && bus.a_req) || (m_own == 2 && bus.b_req);
        e_we   = e_en && (m_own == 1 ? bus.a_we : bus.b_we);
        e_addr = m_own == 1 ? bus.a_addr : bus.b_addr;
        e_wd   = m_own == 1 ? bus.a_wdata : bus.b_wdata;
        chk("a_gnt", 32'(bus.a_gnt), 32'(m_own == 1));
        chk("b_gnt", 32'(bus.b_gnt), 32'(m_own == 2));
        chk("sel", 32'(bus.sel), 32'(m_sel));
        chk("mem_en", 32'(bus.mem_en), 32'(e_en));
        chk("mem_we", 32'(bus.mem_we), 32'(e_we));
        if (e_en) chk("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
        if (e_we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(e_wd));
        if (!reset_n) begin
            m_own = 0; m_last = 2; m_cnt = 0; m_sel = 1'b0;
            q.delete();
        end else begin
            if (e_we) begin
                rmem[e_addr[7:0]] = e_wd;
                rwr[e_addr[7:0]]  = 1'b1;
            end else if (e_en) begin
                q.push_back('{own: m_own, data: rwr[e_addr[7:0]] ? rmem[e_addr[7:0]] : init_val(e_addr[7:0]), due: cyc + L});
            end
            if (m_own == 0) begin
                nx = (bus.a_req && bus.b_req) ? (m_last == 1 ? 2 : 1) : bus.a_req ? 1 : bus.b_req ? 2 : 0;
            end else begin
                rx = m_own == 1 ? bus.a_req : bus.b_req;
                ry = m_own == 1 ? bus.b_req : bus.a_req;
                n  = rx ? ((m_cnt + 1 > MAXH) ? MAXH : m_cnt + 1) : m_cnt;
                nx = (!rx && ry) ? 3 - m_own : !rx ? 0 : (ry && n == MAXH) ? 3 - m_own : m_own;
                m_cnt = n;
            end
            if (nx != 0 && nx != m_own) begin
                m_last = nx; m_cnt = 0; m_sel = (nx == 1);
            end
            m_own = nx;
        end
    end

    // Monitor: each rvalid retires the oldest expected read
    exp_t e;
    always @(negedge clk) begin
        if (bus.a_rvalid || bus.b_rvalid) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL rv_spurious cyc=%0d got=%b%b want=00", cyc, bus.a_rvalid, bus.b_rvalid);
            end else begin
                e = q.pop_front();
                chk("rv_owner", 32'({bus.a_rvalid, bus.b_rvalid}), e.own == 1 ? 32'd2 : 32'd1);
                chk("rv_cycle", 32'(cyc), 32'(e.due));
                chk("rdata", 32'(bus.rdata), 32'(e.data));
            end
        end else if (reset_n && q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            checks++; errors++;
            $display("FAIL rv_missing cyc=%0d got=none want=owner%0d@%0d", cyc, e.own, e.due);
        end
    end

    task automatic drive(input bit ar, input bit aw, input logic [15:0] aa, input logic [15:0] ad,
                         input bit br, input bit bw, input logic [15:0] ba, input logic [15:0] bd);
        @(posedge clk);
        #1;
        bus.a_req = ar; bus.a_we = aw; bus.a_addr = aa; bus.a_wdata = ad;
        bus.b_req = br; bus.b_we = bw; bus.b_addr = ba; bus.b_wdata = bd;
    endtask

    task automatic idle(input int k);
        repeat (k) drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        bus.a_req = 0; bus.a_we = 0; bus.a_addr = 0; bus.a_wdata = 0;
        bus.b_req = 0; bus.b_we = 0; bus.b_addr = 0; bus.b_wdata = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (2) drive(1, 0, 16'h0010, 0, 0, 0, 0, 0);
        idle(5);
        for (int i = 0; i < 14; i++) drive(1, 0, 16'(i), 0, 1, 0, 16'(i + 8), 0);
        idle(5);
        repeat (2) drive(0, 0, 0, 0, 1, 1, 16'h0040, 16'h1234);
        idle(4);
        drive(1, 0, 16'h0040, 0, 0, 0, 0, 0);
        drive(1, 0, 16'h0001, 0, 0, 0, 0, 0);
        drive(1, 0, 16'h0002, 0, 0, 0, 0, 0);
        repeat (2) drive(0, 0, 0, 0, 1, 0, 16'h0003, 0);
        idle(6);
        repeat (2) drive(1, 0, 16'h0005, 0, 0, 0, 0, 0);
        do_reset();
        idle(6);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            else drive($urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0, 16'($urandom_range(0, 31)), 16'($urandom),
                       $urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0, 16'($urandom_range(0, 31)), 16'($urandom));
        end
        idle(L + 3);
        chk("drain", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
